// File: rtl/tiny_cpu_control.sv
// Multi-cycle fetch/decode/execute sequencer driving the TinyCPU datapath
// control word, data-memory strobes and flag-based conditional branches.
//
// state | meaning
// FETCH | request instruction at PC; latch IR and bump PC on InstrValid
// EXEC  | drive control word for IR; ALU/shift/LDI write, branch or dispatch
// MEM   | hold read/write strobe until DataReady; LD writes back on DataReady
// HALT  | stopped; only reset leaves
module tiny_cpu_control #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                InstrReq,
  output logic [PC_WIDTH-1:0] InstrAddr,
  input  logic [15:0]         InstrIn,
  input  logic                InstrValid,
  output logic                DataRead,
  output logic                DataWrite,
  input  logic                DataReady,
  output logic                LoadEnable,
  output logic [1:0]          ASelect,
  output logic [1:0]          BSelect,
  output logic [1:0]          DestinationSelect,
  output logic [15:0]         ConstantIn,
  output logic                MBSelect,
  output logic                MDSelect,
  output logic [3:0]          GSelect,
  output logic [1:0]          HSelect,
  output logic                MFSelect,
  input  logic                statC,
  input  logic                statV,
  input  logic                statN,
  input  logic                statZ,
  output logic                Halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t              state, stateNext;
  logic [PC_WIDTH-1:0] pc, pcNext;
  logic [15:0]         ir;
  logic                irLoad, flagLoad;
  logic                running;
  logic                cf, vf, nf, zf;
  logic [3:0]          op;
  logic [PC_WIDTH-1:0] branchOffset;

  assign op           = ir[15:12];
  assign branchOffset = {{(PC_WIDTH-6){ir[5]}}, ir[5:0]};
  assign InstrAddr    = pc;
  assign ConstantIn   = {10'd0, ir[5:0]};

  // running holds off the first fetch request until one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      running <= 1'b0;
      cf      <= 1'b0;
      vf      <= 1'b0;
      nf      <= 1'b0;
      zf      <= 1'b0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      running <= 1'b1;
      if (irLoad) ir <= InstrIn;
      if (flagLoad) begin
        cf <= statC;
        vf <= statV;
        nf <= statN;
        zf <= statZ;
      end
    end
  end

  always_comb begin
    stateNext         = state;
    pcNext            = pc;
    irLoad            = 1'b0;
    flagLoad          = 1'b0;
    InstrReq          = 1'b0;
    DataRead          = 1'b0;
    DataWrite         = 1'b0;
    LoadEnable        = 1'b0;
    ASelect           = 2'b00;
    BSelect           = 2'b00;
    DestinationSelect = 2'b00;
    MBSelect          = 1'b0;
    MDSelect          = 1'b0;
    GSelect           = 4'b0000;
    HSelect           = 2'b00;
    MFSelect          = 1'b0;
    Halted            = 1'b0;

    case (state)
      FETCH: begin
        if (running) begin
          InstrReq = 1'b1;
          if (InstrValid) begin
            irLoad    = 1'b1;
            pcNext    = pc + PC_WIDTH'(1);
            stateNext = EXEC;
          end
        end
      end

      EXEC: begin
        ASelect           = ir[9:8];
        BSelect           = ir[7:6];
        DestinationSelect = ir[11:10];
        stateNext         = FETCH;
        if (op >= 4'h1 && op <= 4'hA) begin
          LoadEnable = 1'b1;
          flagLoad   = 1'b1;
        end
        case (op)
          4'h1: GSelect = 4'b0010;
          4'h2: GSelect = 4'b0101;
          4'h3: GSelect = 4'b1000;
          4'h4: GSelect = 4'b1010;
          4'h5: GSelect = 4'b1100;
          4'h6: GSelect = 4'b1110;
          4'h7: GSelect = 4'b0001;
          4'h8: begin
            HSelect  = 2'b01;
            MFSelect = 1'b1;
          end
          4'h9: begin
            HSelect  = 2'b10;
            MFSelect = 1'b1;
          end
          4'hA: begin
            MBSelect = 1'b1;
            MFSelect = 1'b1;
          end
          4'hB: begin
            MDSelect  = 1'b1;
            stateNext = MEM;
          end
          4'hC: stateNext = MEM;
          4'hD: if (zf) pcNext = pc + branchOffset;
          4'hE: if (nf) pcNext = pc + branchOffset;
          4'hF: stateNext = HALT;
          default: ;
        endcase
      end

      MEM: begin
        ASelect           = ir[9:8];
        BSelect           = ir[7:6];
        DestinationSelect = ir[11:10];
        // only LD and ST ever reach MEM, so anything not LD is a store
        if (op == 4'hB) begin
          DataRead = 1'b1;
          MDSelect = 1'b1;
          if (DataReady) begin
            LoadEnable = 1'b1;
            stateNext  = FETCH;
          end
        end else begin
          DataWrite = 1'b1;
          if (DataReady) stateNext = FETCH;
        end
      end

      HALT: Halted = 1'b1;

      default: stateNext = FETCH;
    endcase
  end

endmodule
